// File: rtl/ld_cell_a2d_intf.sv
// ld_cell_a2d_intf: SPI master that reads the left load cell, right load cell
// and battery channels of the A2D, one round per nxt pulse. Each channel is a
// command transaction (selects the channel) followed by a read transaction
// that returns the 12-bit conversion result.
`timescale 1ns/1ps
module ld_cell_a2d_intf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        nxt,
   input  logic        MISO,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   output logic [11:0] lft_ld,
   output logic [11:0] rght_ld,
   output logic [11:0] batt,
   output logic        vld
);

   localparam int         DATA_W   = 16;
   localparam int         RES_W    = 12;
   // Divider preload puts the first SCLK fall 9 clks into the transaction.
   localparam logic [4:0] DIV_LOAD = 5'b10111;
   localparam logic [4:0] DIV_SMP  = 5'b01111;
   localparam logic [4:0] DIV_FALL = 5'b11111;
   localparam logic [4:0] GAP_LAST = 5'd31;
   localparam logic [4:0] SMP_LAST = 5'd16;
   localparam logic [1:0] CH_BATT  = 2'd2;

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_GAP1, S_READ, S_GAP2} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [1:0]          r_chan;
   logic [1:0]          w_chan_nxt;
   logic [4:0]          r_div;
   logic [4:0]          r_gap;
   logic [4:0]          r_smp;
   logic [DATA_W-1:0]   r_tx;
   logic [DATA_W-1:0]   r_rx;
   logic [DATA_W-1:0]   w_tx_load;
   logic                r_ss_n;
   logic                r_vld;
   logic [RES_W-1:0]    r_lft;
   logic [RES_W-1:0]    r_rght;
   logic [RES_W-1:0]    r_batt;
   logic                w_start;
   logic                w_in_xfer;
   logic                w_done;
   logic                w_gap_done;

   // Round index (0 left, 1 right, 2 battery) to A2D channel number.
   function automatic logic [2:0] chan_code(input logic [1:0] idx);
      case (idx)
         2'd0:    chan_code = 3'd0;
         2'd1:    chan_code = 3'd4;
         default: chan_code = 3'd5;
      endcase
   endfunction

   assign w_in_xfer  = (r_state == S_CMD) || (r_state == S_READ);
   assign w_done     = w_in_xfer && (r_div == DIV_FALL) && (r_smp == SMP_LAST);
   assign w_gap_done = (r_gap == GAP_LAST);
   assign w_tx_load  = (w_state_nxt == S_CMD) ?
                       {2'b00, chan_code(w_chan_nxt), 11'h000} : {DATA_W{1'b0}};

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; w_start marks the clk SS_n is driven low.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_chan_nxt  = r_chan;
      case (r_state)
         S_IDLE: begin
            if (nxt && !r_vld) begin
               w_state_nxt = S_CMD;
               w_start     = 1'b1;
               w_chan_nxt  = 2'd0;
            end
         end
         S_CMD:  if (w_done) w_state_nxt = S_GAP1;
         S_GAP1: begin
            if (w_gap_done) begin
               w_state_nxt = S_READ;
               w_start     = 1'b1;
            end
         end
         S_READ: if (w_done) w_state_nxt = S_GAP2;
         S_GAP2: begin
            if (r_chan == CH_BATT) begin
               w_state_nxt = S_IDLE;
            end else if (w_gap_done) begin
               w_state_nxt = S_CMD;
               w_start     = 1'b1;
               w_chan_nxt  = r_chan + 2'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // SPI datapath: divider, shifters, gap timer and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ss_n <= 1'b1;
         r_div  <= 5'd0;
         r_gap  <= 5'd0;
         r_smp  <= 5'd0;
         r_tx   <= {DATA_W{1'b0}};
         r_rx   <= {DATA_W{1'b0}};
         r_chan <= 2'd0;
         r_vld  <= 1'b0;
         r_lft  <= {RES_W{1'b0}};
         r_rght <= {RES_W{1'b0}};
         r_batt <= {RES_W{1'b0}};
      end else begin
         r_vld <= 1'b0;
         if (w_start) begin
            r_ss_n <= 1'b0;
            r_div  <= DIV_LOAD;
            r_smp  <= 5'd0;
            r_tx   <= w_tx_load;
            r_rx   <= {DATA_W{1'b0}};
            r_chan <= w_chan_nxt;
         end else if (w_done) begin
            r_ss_n <= 1'b1;
            r_gap  <= 5'd0;
            if (r_state == S_READ) begin
               case (r_chan)
                  2'd0:    r_lft  <= r_rx[RES_W-1:0];
                  2'd1:    r_rght <= r_rx[RES_W-1:0];
                  default: begin
                     r_batt <= r_rx[RES_W-1:0];
                     r_vld  <= 1'b1;
                  end
               endcase
            end
         end else if (w_in_xfer) begin
            r_div <= r_div + 5'd1;
            if (r_div == DIV_SMP) begin
               r_rx  <= {r_rx[DATA_W-2:0], MISO};
               r_smp <= r_smp + 5'd1;
            end
            // The first SCLK fall precedes any sample and must not shift.
            if ((r_div == DIV_FALL) && (r_smp != 5'd0))
               r_tx <= {r_tx[DATA_W-2:0], 1'b0};
         end else if ((r_state == S_GAP1) || (r_state == S_GAP2)) begin
            r_gap <= r_gap + 5'd1;
         end
      end
   end

   assign SS_n    = r_ss_n;
   assign SCLK    = r_ss_n | r_div[4];
   assign MOSI    = r_tx[DATA_W-1];
   assign lft_ld  = r_lft;
   assign rght_ld = r_rght;
   assign batt    = r_batt;
   assign vld     = r_vld;

endmodule
